mac_out_collector: RTL and testbench
====================================

MAC_OUT_COLLECTOR -- requirements
Module: mac_out_collector

Interface
REQ-001 SHALL have parameter outputElements, default 32: lanes per accumulated MAC result vector.
REQ-002 SHALL have parameter accumulatorBits, default 16: width of each lane.
REQ-003 SHALL have parameter lanesPerBeat, default 8: lanes per output beat; outputElements is a multiple of it.
REQ-004 SHALL have parameter fifoDepth, default 4 (power of two, >= 2): number of result vectors buffered.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port nrst, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port mac_valid_i, input, 1: single-cycle pulse marking a result vector; no backpressure is possible.
REQ-008 SHALL have port mac_data_i, input, outputElements x accumulatorBits: result vector, signed two's complement per lane.
REQ-009 SHALL have port stall_o, output, 1: asks the upstream producer to stop issuing new MACs.
REQ-010 SHALL have port overflow_o, output, 1: sticky flag for a dropped vector.
REQ-011 SHALL have port clear_i, input, 1: synchronous clear of overflow_o.
REQ-012 SHALL have port out_valid_o, input-side ready out_ready_i, output/input, 1 each: downstream handshake.
REQ-013 SHALL have port out_data_o, output, lanesPerBeat x accumulatorBits: current beat.
REQ-014 SHALL have port out_beat_o, output, clog2(outputElements/lanesPerBeat): beat index within the vector.
REQ-015 SHALL have port out_last_o, output, 1: high on the final beat of a vector.

Function
REQ-016 SHALL push mac_data_i into the FIFO on every cycle mac_valid_i=1 that the push is accepted.
REQ-017 SHALL accept a push when count<fifoDepth, or when count==fifoDepth and a final-beat pop occurs in the same cycle.
REQ-018 SHALL discard a push when count==fifoDepth with no same-cycle pop, leave FIFO contents unchanged, and set overflow_o the next cycle.
REQ-019 SHALL make a transfer occur only when out_valid_o & out_ready_i.
REQ-020 SHALL implement a 2-state FSM: IDLE (count==0, out_valid_o=0) and SEND (count>0, out_valid_o=1).
REQ-021 SHALL go IDLE->SEND the cycle after an accepted push, and SEND->IDLE after a final-beat transfer that leaves count==0 with no same-cycle push.
REQ-022 SHALL drive out_data_o with lanes [beat*lanesPerBeat +: lanesPerBeat] of the head entry, lane 0 of the beat being the lowest index.
REQ-023 SHALL increment the beat counter on each transfer and wrap it to 0 after the final beat (beat == outputElements/lanesPerBeat-1).
REQ-024 SHALL pop the head entry and advance the read pointer (mod fifoDepth) on the final-beat transfer.
REQ-025 SHALL hold out_data_o, out_beat_o and out_last_o stable while out_valid_o=1 and out_ready_i=0.
REQ-026 SHALL update count as +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-027 SHALL drive stall_o combinationally high when count >= fifoDepth-1, covering one vector already in flight.
REQ-028 SHALL give clear_i priority over overflow set when both occur in the same cycle.
REQ-029 SHALL accept a push arriving while IDLE with latency 1 cycle to out_valid_o.

Reset
REQ-030 SHALL, with nrst=0 at a clk edge, empty the FIFO (count=0, pointers=0), set beat=0, FSM=IDLE, and overflow_o=0.
REQ-031 SHALL hold out_valid_o=0, out_last_o=0, out_beat_o=0, out_data_o=0 and stall_o=0 during and after reset until a push occurs.
REQ-032 SHALL abort any vector partially transmitted at reset mid-operation, with no further beats of it sent.

Configuration
REQ-033 SHALL apply ReLU per lane on out_data_o (negative values become 0) when macro MAC_OUT_COLLECTOR_RELU_EN is defined.
REQ-034 SHALL pass lanes unmodified when MAC_OUT_COLLECTOR_RELU_EN is undefined; FIFO contents are raw in both cases.

Verification
REQ-035 SHALL cover single vector: lanes 0..31 = 0..31, out_ready_i=1 -> 4 beats on consecutive cycles, beat 0 = {0..7}, out_last_o only on beat 3, out_valid_o rising 1 cycle after push.
REQ-036 SHALL cover backpressure: out_ready_i=0 for 5 cycles mid-vector at beat 2 -> out_data_o = lanes 16..23 held; resumes at beat 2.
REQ-037 SHALL cover fill and overflow: 5 pushes with out_ready_i=0 -> stall_o high after 3rd push; 5th dropped; overflow_o=1; the 4 stored vectors emerge in order; clear_i -> overflow_o=0.
REQ-038 SHALL cover full with simultaneous pop: count=4, push coincident with final-beat transfer -> accepted, count stays 4, overflow_o stays 0.
REQ-039 SHALL cover reset mid-vector: nrst=0 after beat 1 -> out_valid_o=0, count=0; next push starts at beat 0.
REQ-040 SHALL cover the ReLU build: lane value -5 (0xFFFB) -> output 0 with MAC_OUT_COLLECTOR_RELU_EN, 0xFFFB without.

Source files
------------

// File: rtl/mac_out_collector.sv
// Buffers full-width MAC result vectors and streams them out as lanesPerBeat-wide beats.
// Optional per-lane ReLU on the output beat is enabled by defining MAC_OUT_COLLECTOR_RELU_EN.
module mac_out_collector #(
  parameter int outputElements  = 32,
  parameter int accumulatorBits = 16,
  parameter int lanesPerBeat    = 8,
  parameter int fifoDepth       = 4
) (
  input  logic                                        clk,
  input  logic                                        nrst,
  input  logic                                        mac_valid_i,
  input  logic [outputElements*accumulatorBits-1:0]   mac_data_i,
  output logic                                        stall_o,
  output logic                                        overflow_o,
  input  logic                                        clear_i,
  output logic                                        out_valid_o,
  input  logic                                        out_ready_i,
  output logic [lanesPerBeat*accumulatorBits-1:0]     out_data_o,
  output logic [((outputElements/lanesPerBeat) > 1 ? $clog2(outputElements/lanesPerBeat) : 1)-1:0] out_beat_o,
  output logic                                        out_last_o
);

  localparam int beatsPerVector = outputElements / lanesPerBeat;
  localparam int beatW          = (beatsPerVector > 1) ? $clog2(beatsPerVector) : 1;
  localparam int vecW           = outputElements * accumulatorBits;
  localparam int beatBits       = lanesPerBeat * accumulatorBits;
  localparam int ptrW           = $clog2(fifoDepth);
  localparam int cntW           = $clog2(fifoDepth + 1);

  localparam logic [cntW-1:0]  depthCnt  = cntW'(fifoDepth);
  localparam logic [cntW-1:0]  stallCnt  = cntW'(fifoDepth - 1);
  localparam logic [beatW-1:0] lastBeat  = beatW'(beatsPerVector - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [vecW-1:0]   mem [fifoDepth];
  logic [ptrW-1:0]   rd_ptr;
  logic [ptrW-1:0]   wr_ptr;
  logic [cntW-1:0]   count;
  logic [beatW-1:0]  beat;

  logic              transfer;
  logic              final_xfer;
  logic              push_ok;
  logic [vecW-1:0]   head;
  logic [beatBits-1:0] head_beat;
  logic [beatBits-1:0] shaped_beat;

  assign out_valid_o = (state == SEND);
  assign transfer    = out_valid_o & out_ready_i;
  assign final_xfer  = transfer & (beat == lastBeat);
  // A full FIFO can still take a vector when the head leaves in the same cycle.
  assign push_ok     = mac_valid_i & ((count < depthCnt) | final_xfer);
  assign stall_o     = (count >= stallCnt);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= mac_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      beat       <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (final_xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (transfer) begin
        beat <= final_xfer ? '0 : beat + 1'b1;
      end
      case ({push_ok, final_xfer})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case (state)
        IDLE: if (push_ok) state <= SEND;
        SEND: if (final_xfer && !push_ok && count == cntW'(1)) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (clear_i) begin
        overflow_o <= 1'b0;
      end else if (mac_valid_i && !push_ok) begin
        overflow_o <= 1'b1;
      end
    end
  end

  assign head      = mem[rd_ptr];
  assign head_beat = head[int'(beat)*beatBits +: beatBits];

  always_comb begin
    shaped_beat = head_beat;
`ifdef MAC_OUT_COLLECTOR_RELU_EN
    for (int l = 0; l < lanesPerBeat; l++) begin
      if (head_beat[l*accumulatorBits + accumulatorBits - 1]) begin
        shaped_beat[l*accumulatorBits +: accumulatorBits] = '0;
      end
    end
`endif
  end

  // Outputs read as zero whenever nothing is queued, including straight out of reset.
  assign out_data_o = out_valid_o ? shaped_beat : '0;
  assign out_beat_o = beat;
  assign out_last_o = out_valid_o & (beat == lastBeat);

endmodule

// File: tb/tb_mac_out_collector.sv
// Bench for mac_out_collector: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_mac_out_collector;

  localparam int outputElements  = 32;
  localparam int accumulatorBits = 16;
  localparam int lanesPerBeat    = 8;
  localparam int fifoDepth       = 4;
  localparam int beats           = outputElements / lanesPerBeat;
  localparam int vecW            = outputElements * accumulatorBits;
  localparam int beatBits        = lanesPerBeat * accumulatorBits;

  logic                clk;
  logic                nrst;
  logic                mac_valid_i;
  logic [vecW-1:0]     mac_data_i;
  logic                stall_o;
  logic                overflow_o;
  logic                clear_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [beatBits-1:0] out_data_o;
  logic [1:0]          out_beat_o;
  logic                out_last_o;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  mac_out_collector #(
    .outputElements (outputElements),
    .accumulatorBits(accumulatorBits),
    .lanesPerBeat   (lanesPerBeat),
    .fifoDepth      (fifoDepth)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .mac_valid_i(mac_valid_i),
    .mac_data_i (mac_data_i),
    .stall_o    (stall_o),
    .overflow_o (overflow_o),
    .clear_i    (clear_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .out_beat_o (out_beat_o),
    .out_last_o (out_last_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [vecW-1:0] actual,
                             input logic [vecW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a queue of whole vectors, the current beat index and the sticky flag.
  logic [vecW-1:0] q[$];
  int              mBeat = 0;
  bit              mOverflow = 0;
  bit              mHadData, mPop, mFull;

  always @(posedge clk) begin
    if (!nrst) begin
      q.delete();
      mBeat     = 0;
      mOverflow = 0;
    end else begin
      mHadData = (q.size() > 0);
      mFull    = (q.size() == fifoDepth);
      mPop     = mHadData && out_ready_i && (mBeat == beats - 1);
      if (mHadData && out_ready_i) mBeat = (mBeat + 1) % beats;
      if (mPop) void'(q.pop_front());
      if (mac_valid_i) begin
        if (!mFull || mPop) q.push_back(mac_data_i);
        else mOverflow = 1;
      end
      if (clear_i) mOverflow = 0;
    end
  end

  function automatic logic [beatBits-1:0] expectedBeat();
    logic [vecW-1:0]     head;
    logic [beatBits-1:0] b;
    if (q.size() == 0) return '0;
    head = q[0];
    b = head[mBeat*beatBits +: beatBits];
`ifdef MAC_OUT_COLLECTOR_RELU_EN
    for (int l = 0; l < lanesPerBeat; l++)
      if ($signed(b[l*accumulatorBits +: accumulatorBits]) < 0) b[l*accumulatorBits +: accumulatorBits] = '0;
`endif
    return b;
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("valid",    vecW'(out_valid_o), vecW'(q.size() > 0));
      checkOutput("data",     vecW'(out_data_o),  vecW'(expectedBeat()));
      checkOutput("beat",     vecW'(out_beat_o),  vecW'(mBeat));
      checkOutput("last",     vecW'(out_last_o),  vecW'(q.size() > 0 && mBeat == beats - 1));
      checkOutput("stall",    vecW'(stall_o),     vecW'(q.size() >= fifoDepth - 1));
      checkOutput("overflow", vecW'(overflow_o),  vecW'(mOverflow));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input logic [vecW-1:0] d, input bit rdy, input bit clr);
    mac_valid_i = v;
    mac_data_i  = d;
    out_ready_i = rdy;
    clear_i     = clr;
    tick();
  endtask

  function automatic logic [vecW-1:0] ramp();
    logic [vecW-1:0] v;
    for (int i = 0; i < outputElements; i++) v[i*accumulatorBits +: accumulatorBits] = 16'(i);
    return v;
  endfunction

  function automatic logic [vecW-1:0] randVec();
    logic [vecW-1:0] v;
    for (int i = 0; i < vecW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  logic [beatBits-1:0] beat0Lit;
  logic [beatBits-1:0] beat2Lit;
  logic [vecW-1:0]     negVec;

  initial begin
    beat0Lit = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    beat2Lit = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
    nrst = 1'b0; mac_valid_i = 1'b0; mac_data_i = '0; out_ready_i = 1'b0; clear_i = 1'b0;
    tick();
    checkEn = 1;
    tick();
    checkOutput("rst_valid", vecW'(out_valid_o), '0);
    checkOutput("rst_data",  vecW'(out_data_o),  '0);
    checkOutput("rst_beat",  vecW'(out_beat_o),  '0);
    checkOutput("rst_stall", vecW'(stall_o),     '0);
    checkOutput("rst_ovf",   vecW'(overflow_o),  '0);
    nrst = 1'b1;
    tick();

    // Single ramp vector streamed with the sink always ready.
    applyStimulus(1, ramp(), 1, 0);
    mac_valid_i = 0;
    checkOutput("single_valid", vecW'(out_valid_o), vecW'(1));
    checkOutput("single_beat0", vecW'(out_data_o), vecW'(beat0Lit));
    checkOutput("single_last0", vecW'(out_last_o), '0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    checkOutput("single_beat2", vecW'(out_data_o), vecW'(beat2Lit));
    applyStimulus(0, '0, 1, 0);
    checkOutput("single_last3", vecW'(out_last_o), vecW'(1));
    applyStimulus(0, '0, 1, 0);
    checkOutput("single_done", vecW'(out_valid_o), '0);

    // Backpressure at beat 2.
    applyStimulus(1, ramp(), 1, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, '0, 0, 0);
      checkOutput("bp_hold_beat", vecW'(out_beat_o), vecW'(2));
      checkOutput("bp_hold_data", vecW'(out_data_o), vecW'(beat2Lit));
    end
    repeat (3) applyStimulus(0, '0, 1, 0);
    checkOutput("bp_done", vecW'(out_valid_o), '0);

    // Fill and overflow.
    applyStimulus(1, randVec(), 0, 0);
    applyStimulus(1, randVec(), 0, 0);
    checkOutput("fill_stall2", vecW'(stall_o), '0);
    applyStimulus(1, randVec(), 0, 0);
    checkOutput("fill_stall3", vecW'(stall_o), vecW'(1));
    applyStimulus(1, randVec(), 0, 0);
    checkOutput("fill_ovf4", vecW'(overflow_o), '0);
    applyStimulus(1, randVec(), 0, 0);
    checkOutput("fill_ovf5", vecW'(overflow_o), vecW'(1));
    repeat (16) applyStimulus(0, '0, 1, 0);
    checkOutput("fill_drained", vecW'(out_valid_o), '0);
    applyStimulus(0, '0, 1, 1);
    checkOutput("fill_clear", vecW'(overflow_o), '0);

    // Full FIFO with a push coinciding with the final-beat pop.
    repeat (4) applyStimulus(1, randVec(), 0, 0);
    repeat (3) applyStimulus(0, '0, 1, 0);
    checkOutput("full_last", vecW'(out_last_o), vecW'(1));
    applyStimulus(1, randVec(), 1, 0);
    checkOutput("full_stall", vecW'(stall_o), vecW'(1));
    checkOutput("full_ovf", vecW'(overflow_o), '0);
    checkOutput("full_beat", vecW'(out_beat_o), '0);
    repeat (16) applyStimulus(0, '0, 1, 0);

    // Reset part-way through a vector.
    applyStimulus(1, ramp(), 1, 0);
    applyStimulus(0, '0, 1, 0);
    nrst = 1'b0;
    applyStimulus(0, '0, 1, 0);
    checkOutput("rstmid_valid", vecW'(out_valid_o), '0);
    checkOutput("rstmid_beat",  vecW'(out_beat_o),  '0);
    nrst = 1'b1;
    applyStimulus(1, ramp(), 0, 0);
    checkOutput("rstmid_restart", vecW'(out_data_o), vecW'(beat0Lit));
    repeat (5) applyStimulus(0, '0, 1, 0);

    // Negative lane through the optional ReLU.
    negVec = ramp();
    negVec[15:0] = 16'hFFFB;
    applyStimulus(1, negVec, 0, 0);
`ifdef MAC_OUT_COLLECTOR_RELU_EN
    checkOutput("relu_lane0", vecW'(out_data_o[15:0]), '0);
`else
    checkOutput("relu_lane0", vecW'(out_data_o[15:0]), vecW'(16'hFFFB));
`endif
    repeat (5) applyStimulus(0, '0, 1, 0);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 3000; i++) begin
      nrst = ($urandom_range(0, 299) != 0);
      applyStimulus($urandom_range(0, 9) < 4, randVec(), $urandom_range(0, 9) < 7,
                    $urandom_range(0, 39) == 0);
    end
    nrst = 1'b1;
    repeat (20) applyStimulus(0, '0, 1, 0);

    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
